uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (data bits, parity, stop bits, baud divider).
// Every output is a flop; the next-state process computes the registered values one cycle ahead.
module uart_tx_cfg #(
  parameter int BAUD_DIV  = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 send_en,
  input  logic [DATA_BITS-1:0] data_byte,
  output logic                 serial_data_tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          baud_cnt, baud_n;
  logic [3:0]             bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shift, shift_n;
  logic                   par_bit, par_n;
  logic                   line_n, busy_n, done_n;
  logic                   bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      baud_cnt       <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      par_bit        <= 1'b0;
      serial_data_tx <= 1'b1;
      tx_busy        <= 1'b0;
      tx_done        <= 1'b0;
    end else begin
      state          <= state_n;
      baud_cnt       <= baud_n;
      bit_cnt        <= bit_n;
      shift          <= shift_n;
      par_bit        <= par_n;
      serial_data_tx <= line_n;
      tx_busy        <= busy_n;
      tx_done        <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud_cnt + CW'(1);
    bit_n   = bit_cnt;
    shift_n = shift;
    par_n   = par_bit;
    line_n  = serial_data_tx;
    done_n  = 1'b0;

    case (state)
      S_IDLE: begin
        baud_n = '0;
        line_n = 1'b1;
        if (send_en) begin
          state_n = S_START;
          shift_n = data_byte;
          // Odd mode inverts the data XOR so data+parity holds an odd count of ones.
          par_n   = (^data_byte) ^ (PARITY == 1);
          line_n  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = '0;
          line_n  = shift[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_n = '0;
            if (PARITY != 0) begin
              state_n = S_PARITY;
              line_n  = par_bit;
            end else begin
              state_n = S_STOP;
              line_n  = 1'b1;
            end
          end else begin
            bit_n  = bit_cnt + 4'd1;
            line_n = shift[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          bit_n   = '0;
          line_n  = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_n = S_IDLE;
            bit_n   = '0;
            done_n  = 1'b1;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
          line_n = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        line_n  = 1'b1;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule
